// File: rtl/digest_arbiter_if.sv
// AXI-Stream bundle shared by the digest arbiter: NUM_LANES streams flattened side by side.
// Lane i occupies slice i of every data, keep and user vector.
interface digest_arbiter_if #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_LANES          = 1
);
    logic [NUM_LANES*C_AXIS_DATA_WIDTH-1:0]     tdata;
    logic [NUM_LANES*C_AXIS_DATA_WIDTH/8-1:0]   tkeep;
    logic [NUM_LANES*C_AXIS_TUSER_WIDTH-1:0]    tuser;
    logic [NUM_LANES-1:0]                       tvalid;
    logic [NUM_LANES-1:0]                       tlast;
    logic [NUM_LANES-1:0]                       tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/digest_arbiter.sv
// Packet-locked round-robin merge of several hash-engine digest streams into one AXI-Stream port.
// Define DIGEST_ARB_STATS_EN to build the per-port packet counters on stat_pkt_count.
module digest_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 2
) (
    input  logic                    axis_aclk,
    input  logic                    reset,
    digest_arbiter_if.slave         s_axis,
    digest_arbiter_if.master        m_axis,
    output logic [1:0]              grant_id,
    output logic [NUM_PORTS*32-1:0] stat_pkt_count
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state;

    // Slave lanes unpacked into fixed 4-entry tables so the 2-bit grant indexes them directly.
    logic [C_AXIS_DATA_WIDTH-1:0]  lane_data [4];
    logic [KEEP_W-1:0]             lane_keep [4];
    logic [C_AXIS_TUSER_WIDTH-1:0] lane_user [4];
    logic [3:0]                    lane_valid;
    logic [3:0]                    lane_last;
    logic [NUM_PORTS-1:0]          lane_ready;

    logic [C_AXIS_DATA_WIDTH-1:0]  out_data;
    logic [KEEP_W-1:0]             out_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] out_user;
    logic                          out_valid;
    logic                          out_last;

    logic out_free;
    logic take;

    function automatic logic [1:0] next_grant(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] pick;
        pick = last;
        // Walk offsets from farthest to nearest so the nearest requester after 'last' wins.
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req[2'((int'(last) + k) % NUM_PORTS)]) begin
                pick = 2'((int'(last) + k) % NUM_PORTS);
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_data[i] = '0;
            lane_keep[i] = '0;
            lane_user[i] = '0;
        end
        lane_valid = '0;
        lane_last  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            lane_data[i]  = s_axis.tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            lane_keep[i]  = s_axis.tkeep[i*KEEP_W +: KEEP_W];
            lane_user[i]  = s_axis.tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
            lane_valid[i] = s_axis.tvalid[i];
            lane_last[i]  = s_axis.tlast[i];
        end
    end

    // The output register can accept a beat when empty or when it is draining this cycle.
    assign out_free = ~out_valid | m_axis.tready[0];
    assign take     = (state == LOCKED) & lane_valid[grant_id] & out_free;

    always_comb begin
        lane_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            lane_ready[i] = (state == LOCKED) && (grant_id == 2'(i)) && out_free;
        end
    end

    assign s_axis.tready = lane_ready;

    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tuser  = out_user;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= 2'(NUM_PORTS - 1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
        end else begin
            if (state == IDLE) begin
                if (|lane_valid) begin
                    grant_id <= next_grant(grant_id, lane_valid);
                    state    <= LOCKED;
                end
            end else if (take && lane_last[grant_id]) begin
                // The last beat may still sit in the output register; arbitration proceeds regardless.
                state <= IDLE;
            end

            if (take) begin
                out_data  <= lane_data[grant_id];
                out_keep  <= lane_keep[grant_id];
                out_user  <= lane_user[grant_id];
                out_last  <= lane_last[grant_id];
                out_valid <= 1'b1;
            end else if (m_axis.tready[0]) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef DIGEST_ARB_STATS_EN
    logic        take_last;
    logic [31:0] pkt_cnt [NUM_PORTS];

    assign take_last = take & lane_last[grant_id];

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (take_last && (grant_id == 2'(i))) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        assign stat_pkt_count[g*32 +: 32] = pkt_cnt[g];
    end
`else
    assign stat_pkt_count = '0;
`endif

endmodule
